dx_stage_param: RTL and testbench

Parametrised decode→execute pipeline register: successor to the fixed two-operand DX latch. Captures one decoded instruction per cycle and resolves operand forwarding internally by register-address compare over `NUM_FWD` prioritised sources. Separates hold (stall) from flush (bubble), refreshes held operands while stalled, and counts stall/flush events. Sits between the decode/register-read stage and the execute stage.

---
 rtl/dx_stage_param_pkg.sv | 9 +
 rtl/dx_stage_param_fwd_mux.sv | 20 ++
 rtl/dx_stage_param.sv | 134 +++++++++++++
 tb/tb_dx_stage_param.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/dx_stage_param_pkg.sv
// definitions: shared register types and decode->execute stage defaults.
package definitions;
    localparam int DX_NUM_FWD = 2;
    localparam int DX_NUM_SRC = 2;
    typedef logic [4:0]  RegAddr;
    typedef logic [31:0] Register;
    // Stall and bubble controls are plain active-high enables.
    typedef enum logic {DISABLED = 1'b0, ENABLED = 1'b1} Signal;
endpackage

// File: rtl/dx_stage_param_fwd_mux.sv
// fwd_mux: picks the youngest matching forward source for one operand, else the base data.
module fwd_mux #(
    parameter int XLEN    = 32,
    parameter int AW      = 5,
    parameter int NUM_FWD = 2
) (
    input  logic [AW-1:0]                  addr_i,
    input  logic [XLEN-1:0]                base_i,
    input  logic [NUM_FWD-1:0]             fwd_valid_i,
    input  logic [NUM_FWD-1:0][AW-1:0]     fwd_a_i,
    input  logic [NUM_FWD-1:0][XLEN-1:0]   fwd_d_i,
    output logic [XLEN-1:0]                data_o
);
    // Walk oldest to youngest so the lowest matching index is applied last; x0 is never forwarded.
    always_comb begin
        data_o = base_i;
        for (int k = NUM_FWD - 1; k >= 0; k--)
            if (fwd_valid_i[k] && fwd_a_i[k] == addr_i && addr_i != '0) data_o = fwd_d_i[k];
    end
endmodule

// File: rtl/dx_stage_param.sv
// dx_stage_param: decode->execute pipeline register with internal forwarding,
// stall refresh, bubble insertion and saturating stall/flush counters.
module dx_stage_param import definitions::*; #(
    parameter int XLEN    = $bits(Register),
    parameter int AW      = $bits(RegAddr),
    parameter int NUM_SRC = DX_NUM_SRC,
    parameter int NUM_FWD = DX_NUM_FWD,
    parameter int CTRL_W  = 16,
    parameter int PERF_W  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [XLEN-1:0]                   in_pc,
    input  logic [NUM_SRC-1:0][AW-1:0]        in_src_a,
    input  logic [NUM_SRC-1:0][XLEN-1:0]      in_src_d,
    input  logic [AW-1:0]                     in_rd_a,
    input  logic [XLEN-1:0]                   in_imm,
    input  logic [CTRL_W-1:0]                 in_ctrl,
    input  logic                              in_reg_write,
    input  logic                              in_mem_write,
    input  logic [NUM_FWD-1:0]                fwd_valid,
    input  logic [NUM_FWD-1:0][AW-1:0]        fwd_a,
    input  logic [NUM_FWD-1:0][XLEN-1:0]      fwd_d,
    input  logic                              hold,
    input  logic                              flush,
    output logic                              out_valid,
    output logic [XLEN-1:0]                   out_pc,
    output logic [NUM_SRC-1:0][AW-1:0]        out_src_a,
    output logic [NUM_SRC-1:0][XLEN-1:0]      out_src_d,
    output logic [AW-1:0]                     out_rd_a,
    output logic [XLEN-1:0]                   out_imm,
    output logic [CTRL_W-1:0]                 out_ctrl,
    output logic                              out_reg_write,
    output logic                              out_mem_write,
    output logic [PERF_W-1:0]                 hold_cnt,
    output logic [PERF_W-1:0]                 flush_cnt
);
    Signal hold_s, flush_s;
    assign hold_s  = Signal'(hold);
    assign flush_s = Signal'(flush);

    logic                         valid_q, valid_d, rw_q, rw_d, mw_q, mw_d;
    logic [XLEN-1:0]              pc_q, pc_d, imm_q, imm_d;
    logic [NUM_SRC-1:0][AW-1:0]   sa_q, sa_d;
    logic [NUM_SRC-1:0][XLEN-1:0] sd_q, sd_d, fwd_res;
    logic [AW-1:0]                rd_q, rd_d;
    logic [CTRL_W-1:0]            ctrl_q, ctrl_d;
    logic [PERF_W-1:0]            hc_q, hc_d, fc_q, fc_d;

    // While stalled the compare runs against the held operand so late producers are still captured.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_mux #(.XLEN(XLEN), .AW(AW), .NUM_FWD(NUM_FWD)) u_fwd (
            .addr_i      (hold_s == ENABLED ? sa_q[i] : in_src_a[i]),
            .base_i      (hold_s == ENABLED ? sd_q[i] : in_src_d[i]),
            .fwd_valid_i (fwd_valid),
            .fwd_a_i     (fwd_a),
            .fwd_d_i     (fwd_d),
            .data_o      (fwd_res[i])
        );
    end

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        sa_d    = sa_q;
        sd_d    = sd_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;
        rw_d    = rw_q;
        mw_d    = mw_q;
        if (flush_s == ENABLED) begin
            valid_d = 1'b0;
            rw_d    = 1'b0;
            mw_d    = 1'b0;
            rd_d    = '0;
        end else if (hold_s == ENABLED) begin
            sd_d = fwd_res;
        end else begin
            valid_d = in_valid;
            pc_d    = in_pc;
            sa_d    = in_src_a;
            sd_d    = fwd_res;
            rd_d    = in_rd_a;
            imm_d   = in_imm;
            ctrl_d  = in_ctrl;
            rw_d    = in_reg_write & in_valid;
            mw_d    = in_mem_write & in_valid;
        end
        hc_d = (hold_s == ENABLED && flush_s == DISABLED && valid_q && hc_q != '1) ? hc_q + PERF_W'(1) : hc_q;
        fc_d = (flush_s == ENABLED && valid_q && fc_q != '1) ? fc_q + PERF_W'(1) : fc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            sa_q    <= '0;
            sd_q    <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            ctrl_q  <= '0;
            rw_q    <= 1'b0;
            mw_q    <= 1'b0;
            hc_q    <= '0;
            fc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            sa_q    <= sa_d;
            sd_q    <= sd_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
            rw_q    <= rw_d;
            mw_q    <= mw_d;
            hc_q    <= hc_d;
            fc_q    <= fc_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = pc_q;
    assign out_src_a     = sa_q;
    assign out_src_d     = sd_q;
    assign out_rd_a      = rd_q;
    assign out_imm       = imm_q;
    assign out_ctrl      = ctrl_q;
    assign out_reg_write = rw_q;
    assign out_mem_write = mw_q;
    assign hold_cnt      = hc_q;
    assign flush_cnt     = fc_q;
endmodule

// File: tb/tb_dx_stage_param.sv
// tb_dx_stage_param: table-driven scoreboard bench for dx_stage_param with 4-bit counters.
module tb_dx_stage_param;
    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_reg_write, in_mem_write, hold, flush;
    logic [31:0]       in_pc, in_imm;
    logic [1:0][4:0]   in_src_a, fwd_a;
    logic [1:0][31:0]  in_src_d, fwd_d;
    logic [4:0]        in_rd_a;
    logic [15:0]       in_ctrl;
    logic [1:0]        fwd_valid;
    logic              out_valid, out_reg_write, out_mem_write;
    logic [31:0]       out_pc, out_imm;
    logic [1:0][4:0]   out_src_a;
    logic [1:0][31:0]  out_src_d;
    logic [4:0]        out_rd_a;
    logic [15:0]       out_ctrl;
    logic [3:0]        hold_cnt, flush_cnt;

    dx_stage_param #(.PERF_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_src_a(in_src_a),
        .in_src_d(in_src_d), .in_rd_a(in_rd_a), .in_imm(in_imm), .in_ctrl(in_ctrl),
        .in_reg_write(in_reg_write), .in_mem_write(in_mem_write), .fwd_valid(fwd_valid),
        .fwd_a(fwd_a), .fwd_d(fwd_d), .hold(hold), .flush(flush), .out_valid(out_valid),
        .out_pc(out_pc), .out_src_a(out_src_a), .out_src_d(out_src_d), .out_rd_a(out_rd_a),
        .out_imm(out_imm), .out_ctrl(out_ctrl), .out_reg_write(out_reg_write),
        .out_mem_write(out_mem_write), .hold_cnt(hold_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v; logic [31:0] pc; logic [1:0][4:0] sa; logic [1:0][31:0] sd; logic [4:0] rd;
        logic rw, mw; logic [1:0] fv; logic [1:0][4:0] fa; logic [1:0][31:0] fd; logic hold, flush;
        logic ev; logic [31:0] epc; logic [1:0][4:0] esa; logic [1:0][31:0] esd; logic [4:0] erd;
        logic erw, emw; logic [3:0] ehc, efc;
    } vec_t;

    vec_t tbl[6];
    vec_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", nm, a, e);
        end
    endtask

    task automatic run(input vec_t t);
        vec_t e;
        in_valid = t.v; in_pc = t.pc; in_src_a = t.sa; in_src_d = t.sd; in_rd_a = t.rd;
        in_imm = t.pc ^ 32'hF0F0; in_ctrl = t.pc[15:0]; in_reg_write = t.rw; in_mem_write = t.mw;
        fwd_valid = t.fv; fwd_a = t.fa; fwd_d = t.fd; hold = t.hold; flush = t.flush;
        exp_q.push_back(t);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("valid", {31'd0, out_valid}, {31'd0, e.ev});
        chk("pc", out_pc, e.epc);
        chk("imm", out_imm, e.epc ^ 32'hF0F0);
        chk("ctrl", {16'd0, out_ctrl}, {16'd0, e.epc[15:0]});
        chk("src_a", {22'd0, out_src_a}, {22'd0, e.esa});
        chk("src_d0", out_src_d[0], e.esd[0]);
        chk("src_d1", out_src_d[1], e.esd[1]);
        chk("rd_a", {27'd0, out_rd_a}, {27'd0, e.erd});
        chk("reg_write", {31'd0, out_reg_write}, {31'd0, e.erw});
        chk("mem_write", {31'd0, out_mem_write}, {31'd0, e.emw});
        chk("hold_cnt", {28'd0, hold_cnt}, {28'd0, e.ehc});
        chk("flush_cnt", {28'd0, flush_cnt}, {28'd0, e.efc});
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({nm, "_pc"}, out_pc, 32'd0);
        chk({nm, "_imm"}, out_imm, 32'd0);
        chk({nm, "_ctrl"}, {16'd0, out_ctrl}, 32'd0);
        chk({nm, "_src_a"}, {22'd0, out_src_a}, 32'd0);
        chk({nm, "_src_d0"}, out_src_d[0], 32'd0);
        chk({nm, "_src_d1"}, out_src_d[1], 32'd0);
        chk({nm, "_rd_a"}, {27'd0, out_rd_a}, 32'd0);
        chk({nm, "_wr"}, {30'd0, out_reg_write, out_mem_write}, 32'd0);
        chk({nm, "_cnt"}, {24'd0, hold_cnt, flush_cnt}, 32'd0);
    endtask

    task automatic randomize_inputs();
        in_valid = 1'b1; in_pc = $urandom; in_src_a = 10'($urandom); in_src_d = {$urandom, $urandom};
        in_rd_a = 5'($urandom); in_imm = $urandom; in_ctrl = 16'($urandom); in_reg_write = 1'b1;
        in_mem_write = 1'b1; fwd_valid = 2'b11; fwd_a = in_src_a; fwd_d = {$urandom, $urandom};
        hold = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t t;
        tbl[0] = '{1'b1, 32'h100, {5'd3, 5'd5}, {32'h33, 32'h55}, 5'd2, 1'b1, 1'b0, 2'b11, {5'd5, 5'd5}, {32'hBBBB, 32'hAAAA}, 1'b0, 1'b0,
                   1'b1, 32'h100, {5'd3, 5'd5}, {32'h33, 32'hAAAA}, 5'd2, 1'b1, 1'b0, 4'd0, 4'd0};
        tbl[1] = '{1'b1, 32'h104, {5'd3, 5'd0}, {32'h33, 32'h55}, 5'd2, 1'b1, 1'b0, 2'b11, {5'd0, 5'd0}, {32'hBBBB, 32'hAAAA}, 1'b0, 1'b0,
                   1'b1, 32'h104, {5'd3, 5'd0}, {32'h33, 32'h55}, 5'd2, 1'b1, 1'b0, 4'd0, 4'd0};
        tbl[2] = '{1'b1, 32'h108, {5'd7, 5'd5}, {32'h1, 32'h2}, 5'd4, 1'b0, 1'b1, 2'b10, {5'd7, 5'd5}, {32'h77, 32'h99}, 1'b0, 1'b0,
                   1'b1, 32'h108, {5'd7, 5'd5}, {32'h77, 32'h2}, 5'd4, 1'b0, 1'b1, 4'd0, 4'd0};
        tbl[3] = '{1'b0, 32'h10C, {5'd1, 5'd2}, {32'h11, 32'h22}, 5'd6, 1'b1, 1'b1, 2'b00, {5'd0, 5'd0}, {32'h0, 32'h0}, 1'b0, 1'b0,
                   1'b0, 32'h10C, {5'd1, 5'd2}, {32'h11, 32'h22}, 5'd6, 1'b0, 1'b0, 4'd0, 4'd0};
        tbl[4] = '{1'b1, 32'h110, {5'd3, 5'd4}, {32'h44, 32'h45}, 5'd8, 1'b1, 1'b1, 2'b00, {5'd0, 5'd0}, {32'h0, 32'h0}, 1'b0, 1'b1,
                   1'b0, 32'h10C, {5'd1, 5'd2}, {32'h11, 32'h22}, 5'd0, 1'b0, 1'b0, 4'd0, 4'd0};
        tbl[5] = '{1'b1, 32'h200, {5'd7, 5'd0}, {32'h1, 32'hDEAD}, 5'd9, 1'b1, 1'b0, 2'b00, {5'd0, 5'd0}, {32'h0, 32'h0}, 1'b0, 1'b0,
                   1'b1, 32'h200, {5'd7, 5'd0}, {32'h1, 32'hDEAD}, 5'd9, 1'b1, 1'b0, 4'd0, 4'd0};

        rst = 1'b0;
        randomize_inputs();
        #2 rst = 1'b1;
        #1 chk_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run(tbl[i]);

        // stall with a producer completing on the second held cycle
        t = '{1'b1, 32'h999, {5'd1, 5'd1}, {32'hF, 32'hF}, 5'd3, 1'b0, 1'b1, 2'b00, {5'd0, 5'd0}, {32'h0, 32'h0}, 1'b1, 1'b0,
              1'b1, 32'h200, {5'd7, 5'd0}, {32'h1, 32'hDEAD}, 5'd9, 1'b1, 1'b0, 4'd1, 4'd0};
        run(t);
        t.fv = 2'b11; t.fa = {5'd7, 5'd0}; t.fd = {32'h77, 32'h1234};
        t.esd = {32'h77, 32'hDEAD}; t.ehc = 4'd2;
        run(t);
        t.fv = 2'b00; t.ehc = 4'd3;
        run(t);
        t.flush = 1'b1; t.ev = 1'b0; t.erd = 5'd0; t.erw = 1'b0; t.efc = 4'd1;
        run(t);

        // saturation of the 4-bit hold counter
        t = '{1'b1, 32'hA00, {5'd2, 5'd3}, {32'h20, 32'h30}, 5'd1, 1'b1, 1'b1, 2'b00, {5'd0, 5'd0}, {32'h0, 32'h0}, 1'b0, 1'b0,
              1'b1, 32'hA00, {5'd2, 5'd3}, {32'h20, 32'h30}, 5'd1, 1'b1, 1'b1, 4'd3, 4'd1};
        run(t);
        t.hold = 1'b1; t.pc = 32'hB00; t.sa = {5'd9, 5'd9};
        for (int j = 1; j <= 20; j++) begin
            t.ehc = (3 + j > 15) ? 4'd15 : 4'(3 + j);
            run(t);
        end
        t.flush = 1'b1; t.ev = 1'b0; t.erd = 5'd0; t.erw = 1'b0; t.emw = 1'b0; t.efc = 4'd2;
        run(t);

        // reset while stalled, then a normal load
        @(negedge clk);
        hold = 1'b1;
        rst = 1'b1;
        #1 chk_zero("midhold");
        @(negedge clk);
        rst = 1'b0;
        t = '{1'b1, 32'hC00, {5'd4, 5'd6}, {32'h40, 32'h60}, 5'd5, 1'b1, 1'b0, 2'b01, {5'd0, 5'd6}, {32'h0, 32'h66}, 1'b0, 1'b0,
              1'b1, 32'hC00, {5'd4, 5'd6}, {32'h40, 32'h66}, 5'd5, 1'b1, 1'b0, 4'd0, 4'd0};
        run(t);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
